// File: rtl/ahb_lite_master.sv
// AHB-Lite single-word master: a command FIFO drives NONSEQ address phases, a data-phase register tracks the transfer in flight.
// Latency: a command pushed into an empty FIFO at edge N is NONSEQ in cycle N+1; its response pulses the cycle after its data phase completes.
// Backpressure: cmd_ready drops when the FIFO holds CMD_DEPTH entries; HREADY=0 holds the bus; responses have no back-pressure.
//
// Ports:
//   HCLK, HRESET                    clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata command push interface (valid-ready)
//   rsp_valid/write/rdata/err       one-cycle completion pulse, returned in command order
//   HADDR/HWRITE/HTRANS/HSIZE/HWDATA AHB-Lite master outputs
//   HRDATA/HREADY/HRESP             AHB-Lite slave responses
module ahb_lite_master #(
    parameter int CMD_DEPTH = 4
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);
    localparam int PW = $clog2(CMD_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Command storage
    logic [31:0]          r_addr_mem  [CMD_DEPTH];
    logic [31:0]          r_wdata_mem [CMD_DEPTH];
    logic [CMD_DEPTH-1:0] r_write_mem;
    logic [PW-1:0]        r_rd_ptr;
    logic [PW-1:0]        r_wr_ptr;
    logic [CW-1:0]        r_count;

    // Data phase / response state
    logic        r_dp_vld;
    logic        r_dp_write;
    logic        r_cancel;
    logic [31:0] r_hwdata;
    logic        r_rsp_valid;
    logic        r_rsp_write;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic w_empty;
    logic w_push;
    logic w_accept;
    logic w_dp_done;

    assign w_empty   = (r_count == '0);
    // Readiness looks only at occupancy: a full FIFO refuses a push even on a popping edge.
    assign cmd_ready = (r_count < CW'(CMD_DEPTH)) && !HRESET;
    assign w_push    = cmd_valid && cmd_ready;

    // Head entry drives the address phase straight from storage; the cancel cycle
    // after the first ERROR beat forces IDLE while the head stays queued for re-issue.
    assign HTRANS    = (!w_empty && !r_cancel) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = w_empty ? 32'h0 : r_addr_mem[r_rd_ptr];
    assign HWRITE    = w_empty ? 1'b0  : r_write_mem[r_rd_ptr];
    assign HSIZE     = 3'b010;
    assign HWDATA    = r_hwdata;

    assign w_accept  = (HTRANS == HTRANS_NONSEQ) && HREADY;
    assign w_dp_done = r_dp_vld && HREADY;

    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp_write;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    // Storage needs no reset: emptiness is defined by the pointers and count.
    always_ff @(posedge HCLK) begin
        if (w_push) begin
            r_addr_mem[r_wr_ptr]  <= cmd_addr;
            r_wdata_mem[r_wr_ptr] <= cmd_wdata;
            r_write_mem[r_wr_ptr] <= cmd_write;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_dp_vld    <= 1'b0;
            r_dp_write  <= 1'b0;
            r_cancel    <= 1'b0;
            r_hwdata    <= 32'h0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else begin
            // Power-of-two depth lets the pointers wrap by natural overflow.
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_accept)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_accept})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            // First ERROR beat (HRESP=1, HREADY=0) cancels the next address phase.
            r_cancel <= r_dp_vld && HRESP && !HREADY;

            // Acceptance overlaps completion of the previous data phase.
            if (w_accept) begin
                r_dp_vld   <= 1'b1;
                r_dp_write <= r_write_mem[r_rd_ptr];
                if (r_write_mem[r_rd_ptr])
                    r_hwdata <= r_wdata_mem[r_rd_ptr];
            end else if (w_dp_done) begin
                r_dp_vld <= 1'b0;
            end

            r_rsp_valid <= w_dp_done;
            if (w_dp_done) begin
                r_rsp_write <= r_dp_write;
                r_rsp_err   <= HRESP;
                r_rsp_rdata <= r_dp_write ? 32'h0 : HRDATA;
            end
        end
    end
endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: reset, single write, pipelined reads, wait states, full FIFO, error cancel, reset mid-burst.
// Latency: inputs driven 1 ns after the rising edge, outputs sampled at that same point before new inputs are applied.
// Backpressure: the bench plays the AHB slave directly through HREADY/HRESP/HRDATA.
module tb_ahb_lite_master;
    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int n_total = 0;
    int n_bad   = 0;

    ahb_lite_master #(.CMD_DEPTH(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic step;
        @(posedge HCLK);
        #1;
    endtask

    task automatic push(input logic wr, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    endtask

    task automatic test_reset;
        HRESET = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h55; cmd_wdata = 32'h66;
        HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
        step; step; step;
        n_total++; if (HTRANS !== 2'b00) begin n_bad++; $display("FAIL rst_htrans got=%b want=00", HTRANS); end
        n_total++; if (HADDR !== 32'h0) begin n_bad++; $display("FAIL rst_haddr got=%h want=0", HADDR); end
        n_total++; if (HWRITE !== 1'b0) begin n_bad++; $display("FAIL rst_hwrite got=%b want=0", HWRITE); end
        n_total++; if (HSIZE !== 3'b010) begin n_bad++; $display("FAIL rst_hsize got=%b want=010", HSIZE); end
        n_total++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_ready got=%b want=0", cmd_ready); end
        n_total++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
        n_total++; if (HWDATA !== 32'h0) begin n_bad++; $display("FAIL rst_hwdata got=%h want=0", HWDATA); end
        cmd_valid = 1'b0;
        HRESET = 1'b0;
        #1;
        n_total++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rel_cmd_ready got=%b want=1", cmd_ready); end
        step;
        n_total++; if (HTRANS !== 2'b00) begin n_bad++; $display("FAIL rel_htrans got=%b want=00", HTRANS); end
    endtask

    task automatic test_single_write;
        push(1'b1, 32'h4000_0010, 32'hDEAD_BEEF);
        step;
        cmd_valid = 1'b0;
        n_total++; if (HTRANS !== 2'b10) begin n_bad++; $display("FAIL wr_htrans got=%b want=10", HTRANS); end
        n_total++; if (HADDR !== 32'h4000_0010) begin n_bad++; $display("FAIL wr_haddr got=%h want=40000010", HADDR); end
        n_total++; if (HWRITE !== 1'b1) begin n_bad++; $display("FAIL wr_hwrite got=%b want=1", HWRITE); end
        step;
        n_total++; if (HWDATA !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_hwdata got=%h want=deadbeef", HWDATA); end
        n_total++; if (HTRANS !== 2'b00) begin n_bad++; $display("FAIL wr_idle got=%b want=00", HTRANS); end
        n_total++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL wr_rsp_early got=%b want=0", rsp_valid); end
        step;
        n_total++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL wr_rsp_valid got=%b want=1", rsp_valid); end
        n_total++; if (rsp_write !== 1'b1) begin n_bad++; $display("FAIL wr_rsp_write got=%b want=1", rsp_write); end
        n_total++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL wr_rsp_err got=%b want=0", rsp_err); end
        n_total++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL wr_rsp_rdata got=%h want=0", rsp_rdata); end
        step;
        n_total++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL wr_rsp_pulse got=%b want=0", rsp_valid); end
        n_total++; if (HWDATA !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_hwdata_hold got=%h want=deadbeef", HWDATA); end
    endtask

    task automatic test_pipelined_reads;
        logic [1:0]  exp_tr [1:5];
        logic [31:0] exp_ad [1:5];
        logic [31:0] drv_rd [1:5];
        logic        exp_rv [1:5];
        logic [31:0] exp_rd [1:5];
        exp_tr = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        exp_ad = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h0};
        drv_rd = '{32'h0, 32'h11, 32'h22, 32'h33, 32'h0};
        exp_rv = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_rd = '{32'h0, 32'h0, 32'h11, 32'h22, 32'h33};
        push(1'b0, 32'h0, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            step;
            n_total++; if (HTRANS !== exp_tr[i]) begin n_bad++; $display("FAIL rd_htrans[%0d] got=%b want=%b", i, HTRANS, exp_tr[i]); end
            n_total++; if (HADDR !== exp_ad[i]) begin n_bad++; $display("FAIL rd_haddr[%0d] got=%h want=%h", i, HADDR, exp_ad[i]); end
            n_total++; if (rsp_valid !== exp_rv[i]) begin n_bad++; $display("FAIL rd_rsp_valid[%0d] got=%b want=%b", i, rsp_valid, exp_rv[i]); end
            if (exp_rv[i]) begin
                n_total++; if (rsp_rdata !== exp_rd[i]) begin n_bad++; $display("FAIL rd_rsp_rdata[%0d] got=%h want=%h", i, rsp_rdata, exp_rd[i]); end
                n_total++; if (rsp_write !== 1'b0) begin n_bad++; $display("FAIL rd_rsp_write[%0d] got=%b want=0", i, rsp_write); end
            end
            HRDATA = drv_rd[i];
            if (i < 3) push(1'b0, 32'(4 * i), 32'h0);
            else cmd_valid = 1'b0;
        end
        step;
        n_total++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_rsp_end got=%b want=0", rsp_valid); end
    endtask

    task automatic test_wait_states;
        push(1'b0, 32'h8, 32'h0);
        step;
        n_total++; if (HADDR !== 32'h8) begin n_bad++; $display("FAIL ws_first_addr got=%h want=8", HADDR); end
        push(1'b0, 32'hC, 32'h0);
        step;
        cmd_valid = 1'b0; HREADY = 1'b0; HRDATA = 32'hBAD0_0BAD;
        n_total++; if (HADDR !== 32'hC || HTRANS !== 2'b10) begin n_bad++; $display("FAIL ws_addr0 got=%h/%b want=c/10", HADDR, HTRANS); end
        for (int k = 1; k <= 3; k++) begin
            step;
            n_total++; if (HADDR !== 32'hC || HTRANS !== 2'b10 || HWRITE !== 1'b0) begin n_bad++; $display("FAIL ws_hold[%0d] got=%h/%b/%b want=c/10/0", k, HADDR, HTRANS, HWRITE); end
            n_total++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL ws_rsp_wait[%0d] got=%b want=0", k, rsp_valid); end
        end
        HREADY = 1'b1; HRDATA = 32'h0000_00AB;
        step;
        HRDATA = 32'h0000_00CD;
        n_total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hAB) begin n_bad++; $display("FAIL ws_rsp8 got=%b/%h want=1/ab", rsp_valid, rsp_rdata); end
        n_total++; if (HTRANS !== 2'b00) begin n_bad++; $display("FAIL ws_idle got=%b want=00", HTRANS); end
        step;
        n_total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCD) begin n_bad++; $display("FAIL ws_rspc got=%b/%h want=1/cd", rsp_valid, rsp_rdata); end
        step;
        n_total++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL ws_rsp_end got=%b want=0", rsp_valid); end
    endtask

    task automatic test_full_fifo;
        logic [31:0] exp_ad;
        logic [1:0]  exp_tr;
        HREADY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(1'b0, 32'(32'h200 + 4 * i), 32'h0);
            #1;
            n_total++; if (cmd_ready !== (i < 4)) begin n_bad++; $display("FAIL full_ready[%0d] got=%b want=%b", i, cmd_ready, (i < 4)); end
            step;
        end
        cmd_valid = 1'b0;
        for (int j = 0; j <= 6; j++) begin
            if (j > 0) step;
            exp_tr = (j <= 3) ? 2'b10 : 2'b00;
            exp_ad = (j <= 3) ? 32'(32'h200 + 4 * j) : 32'h0;
            n_total++; if (HTRANS !== exp_tr || HADDR !== exp_ad) begin n_bad++; $display("FAIL drain_addr[%0d] got=%b/%h want=%b/%h", j, HTRANS, HADDR, exp_tr, exp_ad); end
            n_total++; if (rsp_valid !== (j >= 2 && j <= 5)) begin n_bad++; $display("FAIL drain_rsp_valid[%0d] got=%b want=%b", j, rsp_valid, (j >= 2 && j <= 5)); end
            if (j >= 2 && j <= 5) begin
                n_total++; if (rsp_rdata !== 32'(32'hA0 + j - 2)) begin n_bad++; $display("FAIL drain_rdata[%0d] got=%h want=%h", j, rsp_rdata, 32'(32'hA0 + j - 2)); end
            end
            if (j == 0) begin
                n_total++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL full_pop_ready got=%b want=0", cmd_ready); end
                HREADY = 1'b1;
                push(1'b0, 32'h300, 32'h0);
            end else begin
                if (j == 1) begin
                    n_total++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL drain_ready got=%b want=1", cmd_ready); end
                end
                cmd_valid = 1'b0;
                HRDATA = 32'(32'hA0 + j - 1);
            end
        end
    endtask

    task automatic test_error;
        push(1'b0, 32'h100, 32'h0);
        step;
        push(1'b0, 32'h104, 32'h0);
        step;
        cmd_valid = 1'b0;
        n_total++; if (HTRANS !== 2'b10 || HADDR !== 32'h104) begin n_bad++; $display("FAIL err_pre got=%b/%h want=10/104", HTRANS, HADDR); end
        HRESP = 1'b1; HREADY = 1'b0; HRDATA = 32'hEE;
        step;
        n_total++; if (HTRANS !== 2'b00) begin n_bad++; $display("FAIL err_cancel got=%b want=00", HTRANS); end
        n_total++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL err_rsp_early got=%b want=0", rsp_valid); end
        HRESP = 1'b1; HREADY = 1'b1;
        step;
        n_total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin n_bad++; $display("FAIL err_rsp got=%b/%b want=1/1", rsp_valid, rsp_err); end
        n_total++; if (rsp_rdata !== 32'hEE) begin n_bad++; $display("FAIL err_rdata got=%h want=ee", rsp_rdata); end
        n_total++; if (HTRANS !== 2'b10 || HADDR !== 32'h104) begin n_bad++; $display("FAIL err_reissue got=%b/%h want=10/104", HTRANS, HADDR); end
        HRESP = 1'b0;
        step;
        HRDATA = 32'h5A;
        n_total++; if (rsp_valid !== 1'b0 || HTRANS !== 2'b00) begin n_bad++; $display("FAIL err_gap got=%b/%b want=0/00", rsp_valid, HTRANS); end
        step;
        n_total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h5A) begin n_bad++; $display("FAIL err_next got=%b/%b/%h want=1/0/5a", rsp_valid, rsp_err, rsp_rdata); end
        step;
    endtask

    task automatic test_reset_mid;
        push(1'b1, 32'h400, 32'h1);
        step;
        push(1'b1, 32'h404, 32'h2);
        step;
        HREADY = 1'b0;
        push(1'b1, 32'h408, 32'h3);
        step;
        push(1'b1, 32'h40C, 32'h4);
        step;
        cmd_valid = 1'b0;
        n_total++; if (HTRANS !== 2'b10 || HADDR !== 32'h404) begin n_bad++; $display("FAIL rm_pre got=%b/%h want=10/404", HTRANS, HADDR); end
        n_total++; if (HWDATA !== 32'h1) begin n_bad++; $display("FAIL rm_hwdata got=%h want=1", HWDATA); end
        HRESET = 1'b1; HREADY = 1'b1;
        #1;
        n_total++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rm_ready_in_rst got=%b want=0", cmd_ready); end
        step;
        HRESET = 1'b0;
        #1;
        n_total++; if (HTRANS !== 2'b00 || HADDR !== 32'h0) begin n_bad++; $display("FAIL rm_idle got=%b/%h want=00/0", HTRANS, HADDR); end
        n_total++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rm_ready got=%b want=1", cmd_ready); end
        n_total++; if (HWDATA !== 32'h0) begin n_bad++; $display("FAIL rm_hwdata_clr got=%h want=0", HWDATA); end
        for (int k = 0; k < 4; k++) begin
            n_total++; if (rsp_valid !== 1'b0 || HTRANS !== 2'b00) begin n_bad++; $display("FAIL rm_quiet[%0d] got=%b/%b want=0/00", k, rsp_valid, HTRANS); end
            step;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_single_write;
        test_pipelined_reads;
        test_wait_states;
        test_full_fifo;
        test_error;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/ahb_lite_master.md
AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 Parameter CMD_DEPTH, default 4, SHALL set command FIFO depth in entries (power of 2, >=2).
REQ-002 Ports SHALL use one clock and a synchronous, active-high reset:
- HCLK  in  1  clock, all state updates on rising edge
- HRESET  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO can accept
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  32  byte address, word aligned
- cmd_wdata  in  32  write data
- rsp_valid  out  1  one-cycle pulse, transfer completed
- rsp_write  out  1  completed transfer was a write
- rsp_rdata  out  32  read data (0 for writes)
- rsp_err  out  1  completed transfer got ERROR response
- HADDR  out  32  AHB address phase address
- HWRITE  out  1  AHB address phase direction
- HTRANS  out  2  2'b00 IDLE or 2'b10 NONSEQ only
- HSIZE  out  3  constant 3'b010 (word)
- HWDATA  out  32  AHB write data, data phase
- HRDATA  in  32  AHB read data
- HREADY  in  1  slave ready / phase advance
- HRESP  in  1  0=OKAY, 1=ERROR

Function
REQ-003 Command SHALL be pushed into FIFO on a rising edge with cmd_valid=1 and cmd_ready=1.
REQ-004 cmd_ready SHALL equal (count<CMD_DEPTH) and HRESET=0; it SHALL NOT depend on a same-cycle pop (full + simultaneous pop: push refused).
REQ-005 FIFO non-empty: HTRANS=NONSEQ, HADDR/HWRITE = head entry, combinationally from FIFO storage; empty: HTRANS=IDLE, HADDR=0, HWRITE=0.
REQ-006 Latency: command pushed at edge N SHALL appear as NONSEQ in cycle N+1 if FIFO was empty and no error cancel active.
REQ-007 Address phase SHALL be accepted on an edge with HTRANS=NONSEQ and HREADY=1; only then is the head popped and data-phase register loaded (valid, write, wdata, addr).
REQ-008 HWDATA SHALL present the accepted write's data from the cycle after acceptance until its data phase completes; unchanged otherwise.
REQ-009 Data phase SHALL complete on the first edge with data-phase valid and HREADY=1; back-to-back transfers SHALL overlap (next address phase accepted on same edge).
REQ-010 On completion, rsp_valid SHALL pulse high for exactly the next cycle with rsp_write, rsp_err=HRESP, rsp_rdata=HRDATA sampled at that edge for reads, 0 for writes.
REQ-011 While HREADY=0 with HRESP=0, HADDR/HWRITE/HTRANS SHALL hold stable (no pop, no head change even if pushes occur).
REQ-012 Error: on an edge sampling HRESP=1, HREADY=0, master SHALL drive HTRANS=IDLE for the following cycle (cancel); the cancelled head stays in FIFO and is re-issued as NONSEQ after the error completes.
REQ-013 Errors SHALL NOT stop the queue; subsequent commands proceed normally.
REQ-014 Responses SHALL be returned strictly in command order; no ready/back-pressure on rsp.
REQ-015 FIFO pointers SHALL wrap modulo CMD_DEPTH; count 0..CMD_DEPTH exact.

Reset
REQ-016 While HRESET=1 at an edge: FIFO emptied, data phase invalidated, cancel flag cleared, HWDATA=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_err=0; outputs thus HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=3'b010, cmd_ready=0.
REQ-017 Reset mid-transfer SHALL drop queued and in-flight transfers with no rsp_valid generated for them.

Verification
REQ-018 Single write: push write 0x4000_0010/0xDEAD_BEEF, HREADY=1 -> NONSEQ next cycle, HWDATA=0xDEAD_BEEF following cycle, rsp_valid pulse rsp_write=1 rsp_err=0.
REQ-019 Pipelined reads: push reads 0x0,0x4,0x8, slave returns 0x11,0x22,0x33 -> three consecutive NONSEQ cycles, rsp_rdata 0x11,0x22,0x33 in order on consecutive cycles.
REQ-020 Wait states: HREADY=0 for 3 cycles during read data phase of 0x8 -> next address 0xC held stable, single rsp_valid after HREADY rises.
REQ-021 Full FIFO: CMD_DEPTH=4, HREADY=0, push 5 commands -> cmd_ready=0 after 4th, 5th not accepted; releasing HREADY drains all 4 in order.
REQ-022 Error: read 0x100 gets HRESP=1/HREADY=0 then HRESP=1/HREADY=1, next command 0x104 queued -> HTRANS=IDLE one cycle, rsp_err=1 for 0x100, 0x104 re-issued and completes rsp_err=0.
REQ-023 Reset mid-burst: HRESET=1 with 3 queued and 1 in data phase -> HTRANS=IDLE, no rsp_valid, cmd_ready=1 first cycle after release.
